// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined MIPS core: memory-stage states, word type and link width.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  localparam int LINK_W = 30;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} memstate_t;

  function automatic logic [LINK_W-1:0] word_idx(input word_t a);
    return a[31:2];
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// Data-cache request/response bundle between the memory stage and the cache.
interface mem_stage_if;
  import cpu_types_pkg::*;
  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  dhit;
  word_t dload;

  modport ms (output dmemREN, dmemWEN, dmemaddr, dmemstore, input dhit, dload);
  modport tb (input dmemREN, dmemWEN, dmemaddr, dmemstore, output dhit, dload);
endinterface

// File: rtl/link_register.sv
// LL/SC link: valid bit plus word index, set by LL, cleared by SC, local store or remote snoop.
module link_register
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              set,
  input  logic              clr_sc,
  input  logic              st_hit,
  input  logic [LINK_W-1:0] addr,
  input  logic              snoop_inv,
  input  logic [LINK_W-1:0] snoop_idx,
  output logic              match
);
  logic              link_valid;
  logic [LINK_W-1:0] link_addr;
  logic              clr;

  assign match = link_valid && (link_addr == addr);
  assign clr   = clr_sc | (st_hit && (link_addr == addr)) | (snoop_inv && (snoop_idx == link_addr));

  // set has priority so an LL completing alongside a snoop keeps its link
  always_ff @(posedge CLK) begin
    if (RST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (set) begin
      link_valid <= 1'b1;
      link_addr  <= addr;
    end else if (clr) begin
      link_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues data-cache requests, stalls until dhit, holds the result for MEM/WB.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter bit LINK_EN = 1'b1
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  valid,
  input  logic  MemRead,
  input  logic  MemWrite,
  input  logic  LL,
  input  logic  SC,
  input  logic  halt,
  input  word_t port_out,
  input  word_t rt_data,
  input  logic  advance,
  input  logic  snoop_inv,
  input  word_t snoop_addr,
  mem_stage_if.ms dif,
  output logic  mem_stall,
  output word_t dmemload,
  output logic  halt_out
);
  memstate_t state, nstate;
  word_t     load_q;
  logic      memop, sc_fail, issue, link_match;
  logic      ren, wen, stall, hit;
  logic      unused_bits;

  assign unused_bits = ^{port_out[1:0], snoop_addr[1:0]};

  assign memop   = valid & (MemRead | MemWrite | LL | SC) & ~halt;
  assign sc_fail = LINK_EN & SC & ~link_match;
  assign issue   = memop & ~sc_fail;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= nstate;
  end

  // BUSY re-drives from the frozen EX/MEM inputs without re-checking the link,
  // so a snoop landing mid-request cannot drop an SC write already in flight.
  always_comb begin
    nstate = state;
    ren    = 1'b0;
    wen    = 1'b0;
    stall  = 1'b0;
    hit    = 1'b0;
    case (state)
      IDLE: if (memop) begin
        stall = 1'b1;
        if (issue) begin
          ren    = MemRead | LL;
          wen    = MemWrite | SC;
          hit    = dif.dhit;
          nstate = dif.dhit ? DONE : BUSY;
        end else begin
          nstate = DONE;
        end
      end
      BUSY: begin
        stall = 1'b1;
        ren   = MemRead | LL;
        wen   = MemWrite | SC;
        hit   = dif.dhit;
        if (dif.dhit) nstate = DONE;
      end
      DONE: if (advance) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign dif.dmemREN   = ren & ~RST;
  assign dif.dmemWEN   = wen & ~RST;
  assign dif.dmemaddr  = (dif.dmemREN | dif.dmemWEN) ? {port_out[31:2], 2'b00} : '0;
  assign dif.dmemstore = dif.dmemWEN ? rt_data : '0;
  assign mem_stall     = stall & ~RST;
  assign dmemload      = load_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      load_q   <= '0;
      halt_out <= 1'b0;
    end else begin
      if (hit)                                  load_q <= SC ? 32'd1 : dif.dload;
      else if (state == IDLE && memop && sc_fail) load_q <= '0;
      if (valid && halt) halt_out <= 1'b1;
    end
  end

  link_register u_link (
    .CLK       (CLK),
    .RST       (RST),
    .set       (LINK_EN & hit & LL),
    .clr_sc    (hit & SC),
    .st_hit    (hit & MemWrite),
    .addr      (word_idx(port_out)),
    .snoop_inv (snoop_inv),
    .snoop_idx (word_idx(snoop_addr)),
    .match     (link_match)
  );
endmodule
